// File: rtl/mac_operand_loader_pkg.sv
// Shared constants and types for the MAC operand loader and the MAC read sequencer.
package mac_operand_loader_pkg;

  localparam int unsigned NUM_BANKS = 6;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  typedef logic [2:0] lane_t;

  // Bank slot of each operand within one vector
  localparam lane_t SLOT_A1 = 3'd0;
  localparam lane_t SLOT_B1 = 3'd1;
  localparam lane_t SLOT_A2 = 3'd2;
  localparam lane_t SLOT_B2 = 3'd3;
  localparam lane_t SLOT_A3 = 3'd4;
  localparam lane_t SLOT_B3 = 3'd5;

endpackage

// File: rtl/mac_loader_cursor.sv
// Lane / address / remaining-vector counters for the operand loader.
module mac_loader_cursor #(
  parameter int unsigned NUM_BANKS = 6,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  vec_count,
  input  logic              advance,
  output logic [2:0]        lane,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  remaining,
  output logic              last_beat
);
  import mac_operand_loader_pkg::*;

  localparam lane_t LAST_LANE = lane_t'(NUM_BANKS - 1);

  lane_t lane_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      lane_q    <= '0;
      cur_addr  <= base_addr;
      remaining <= vec_count;
    end else if (advance) begin
      if (lane_q == LAST_LANE) begin
        lane_q    <= '0;
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end else begin
        lane_q <= lane_q + lane_t'(1);
      end
    end
  end

  assign lane      = lane_q;
  assign last_beat = (lane_q == LAST_LANE) && (remaining == CNT_W'(1));

endmodule

// File: rtl/mac_operand_loader.sv
// Streams 16-bit operand words round-robin into six BRAM banks, one vector per address.
module mac_operand_loader #(
  parameter int unsigned NUM_BANKS = 6,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [CNT_W-1:0]            vec_count,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [NUM_BANKS*ADDR_W-1:0] bram_addr,
  output logic [NUM_BANKS*DATA_W-1:0] bram_data_in,
  output logic [NUM_BANKS-1:0]        bram_we,
  output logic                        busy,
  output logic                        done
);
  import mac_operand_loader_pkg::*;

  loader_state_t     state_q, state_d;
  logic              accept;
  logic              load;
  logic [2:0]        lane;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              last_beat;

  assign accept = in_valid && in_ready;
  assign load   = (state_q == IDLE) && start;

  mac_loader_cursor #(
    .NUM_BANKS (NUM_BANKS),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .base_addr (base_addr),
    .vec_count (vec_count),
    .advance   (accept),
    .lane      (lane),
    .cur_addr  (cur_addr),
    .remaining (remaining),
    .last_beat (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (vec_count == '0) ? DONE : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data slices keep their last value between writes; only we is pulsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_we      <= '0;
      bram_addr    <= '0;
      bram_data_in <= '0;
    end else begin
      bram_we <= accept ? (NUM_BANKS'(1) << lane) : '0;
      if (accept) begin
        bram_addr[int'(lane)*ADDR_W +: ADDR_W]    <= cur_addr;
        bram_data_in[int'(lane)*DATA_W +: DATA_W] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Scoreboard bench for mac_operand_loader.
module tb_mac_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  vec_count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [47:0] bram_addr;
  logic [95:0] bram_data_in;
  logic [5:0]  bram_we;
  logic        busy;
  logic        done;

  mac_operand_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .vec_count    (vec_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .bram_addr    (bram_addr),
    .bram_data_in (bram_data_in),
    .bram_we      (bram_we),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned lane;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_writes = 0;
  int unsigned n_done = 0;

  int unsigned m_base;
  int unsigned m_count;
  int unsigned m_beat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: sample shortly after each rising edge
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      if (done) n_done++;
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        n_writes++;
        check("we", 32'(bram_we), 32'(6'b1 << e.lane));
        check("addr", 32'(bram_addr[e.lane*8 +: 8]), 32'(e.addr));
        check("data", 32'(bram_data_in[e.lane*16 +: 16]), 32'(e.data));
        check("done_with_last", 32'(done), 32'(e.last));
      end else if (bram_we != '0) begin
        check("we_idle", 32'(bram_we), 32'h0);
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; vec_count = c;
    @(posedge clk); #1;
    start = 1'b0;
    m_base = b; m_count = c; m_beat = 0;
  endtask

  task automatic send_word(input logic [15:0] d);
    wr_t e;
    bit  ok = 0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("ready_timeout", 32'(in_ready), 32'h1);
      in_valid = 1'b0;
      return;
    end
    e.lane = m_beat % 6;
    e.addr = 8'((m_base + m_beat / 6) % 256);
    e.data = d;
    e.last = (m_beat == m_count * 6 - 1);
    exp_q.push_back(e);
    m_beat++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_reached", 32'(ok), 32'h1);
    check("queue_drained", exp_q.size(), 32'h0);
  endtask

  int unsigned d0, w0;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; vec_count = '0;
    in_valid = 1'b0; in_data = '0;
    #2;
    check("rst_we", 32'(bram_we), 32'h0);
    check("rst_addr", bram_addr[31:0], 32'h0);
    check("rst_data", bram_data_in[31:0], 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Basic single-vector load
    d0 = n_done; w0 = n_writes;
    do_start(8'd1, 9'd1);
    for (int i = 0; i < 6; i++) send_word(16'h0011 + 16'(i));
    wait_idle();
    check("basic_writes", n_writes - w0, 32'd6);
    check("basic_done", n_done - d0, 32'd1);

    // Three vectors with an idle cycle after every two words
    d0 = n_done; w0 = n_writes;
    do_start(8'd10, 9'd3);
    for (int i = 0; i < 18; i++) begin
      send_word(16'h1000 + 16'(i * 7));
      if (i % 2 == 1) begin @(posedge clk); #1; end
    end
    wait_idle();
    check("gap_writes", n_writes - w0, 32'd18);
    check("gap_done", n_done - d0, 32'd1);

    // Address wrap from 255 to 0
    d0 = n_done; w0 = n_writes;
    do_start(8'd255, 9'd2);
    for (int i = 0; i < 12; i++) send_word(16'hA500 + 16'(i));
    wait_idle();
    check("wrap_writes", n_writes - w0, 32'd12);
    check("wrap_done", n_done - d0, 32'd1);

    // Zero-count load
    d0 = n_done; w0 = n_writes;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd99; vec_count = 9'd0; in_valid = 1'b1;
    @(negedge clk);
    check("zero_ready_start", 32'(in_ready), 32'h0);
    check("zero_busy_start", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h1);
    check("zero_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("zero_done_after", 32'(done), 32'h0);
    check("zero_busy_after", 32'(busy), 32'h0);
    check("zero_ready_after", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    check("zero_writes", n_writes - w0, 32'd0);
    check("zero_done_count", n_done - d0, 32'd1);

    // Start while busy is ignored
    d0 = n_done; w0 = n_writes;
    do_start(8'd5, 9'd1);
    for (int i = 0; i < 3; i++) send_word(16'h0500 + 16'(i));
    start = 1'b1; base_addr = 8'd50; vec_count = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 3; i < 6; i++) send_word(16'h0500 + 16'(i));
    wait_idle();
    check("busy_start_writes", n_writes - w0, 32'd6);
    check("busy_start_done", n_done - d0, 32'd1);

    // Reset in the middle of a load
    d0 = n_done;
    do_start(8'd20, 9'd2);
    for (int i = 0; i < 3; i++) send_word(16'hBEE0 + 16'(i));
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(bram_we), 32'h0);
    check("midrst_ready", 32'(in_ready), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    check("midrst_no_done", n_done - d0, 32'd0);
    w0 = n_writes;
    do_start(8'd7, 9'd1);
    for (int i = 0; i < 6; i++) send_word(16'h7700 + 16'(i));
    wait_idle();
    check("restart_writes", n_writes - w0, 32'd6);
    check("restart_done", n_done - d0, 32'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mac_operand_loader.md
Name: mac_operand_loader

Overview:
- Write-side counterpart to the MAC-with-BRAM datapath. It accepts a valid/ready stream of 16-bit operand words and fills the six operand BRAM banks: a1, b1, a2, b2, a3, b3 → banks 0..5.
- One operand vector = 6 consecutive beats, written round-robin across the banks, all at the same address. Then the address advances.
- Sits between the host/test stimulus and the bank write ports. Once the loader reports done, the MAC read sequencer may run.

Parameters:
- NUM_BANKS, 6, number of operand banks (lane count per vector)
- ADDR_W, 8, bank address width (256-deep banks)
- DATA_W, 16, bank word width
- CNT_W, 9, width of vector count (allows 0..256)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- base_addr  in  ADDR_W  first bank address; captured on accepted start
- vec_count  in  CNT_W  number of vectors to load; captured on accepted start
- in_valid  in  1  operand word valid
- in_data  in  DATA_W  operand word
- in_ready  out  1  loader can accept a word
- bram_addr  out  NUM_BANKS*ADDR_W  per-bank address, bank i at [i*ADDR_W +: ADDR_W]
- bram_data_in  out  NUM_BANKS*DATA_W  per-bank write data, same packing
- bram_we  out  NUM_BANKS  per-bank write enable
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - bram_addr, bram_data_in, bram_we, done, busy, in_ready all 0.
  - Internal lane, addr and vector counters cleared.
- States: IDLE, LOAD, DONE.
  - IDLE→LOAD: start=1 and vec_count≠0. Captures base_addr into cur_addr and vec_count into remaining; lane=0.
  - IDLE→DONE: start=1 and vec_count=0. No writes occur.
  - LOAD→DONE: on the accepted beat with lane=NUM_BANKS-1 and remaining=1.
  - DONE→IDLE: unconditional, next cycle.
- in_ready = (state==LOAD). It is driven from the state register only; no combinational path from in_valid.
- Accept = in_valid & in_ready.
- On accept in cycle T, registered outputs at T+1:
  - bram_we[lane]=1; every other we bit=0.
  - bram_addr slice [lane] = cur_addr.
  - bram_data_in slice [lane] = in_data.
  - Write latency is exactly 1 cycle.
- Cycles with no accept: all bram_we bits are 0. Addr/data slices hold their previous values.
- Counter update per accept:
  - lane increments.
  - When lane=NUM_BANKS-1: lane→0, cur_addr→cur_addr+1 (mod 2^ADDR_W), remaining→remaining-1.
- Address wrap: base_addr+vec_count > 256 wraps silently to 0. vec_count=256 with base_addr=0 writes every address once.
- done: high for exactly the one cycle state==DONE.
  - For a non-empty load, this cycle coincides with the final bram_we pulse.
  - For a zero-count load, done appears the cycle after start.
- busy: high in LOAD and DONE.
- start while busy: ignored; captured values are unchanged.
- start and in_valid in the same IDLE cycle: the word is not accepted (in_ready=0). The first accept can occur the cycle after start.
- in_valid gaps: allowed at any lane position. The counters stall and no write is generated.
- Reset mid-LOAD:
  - Immediate return to IDLE; we drops in the same cycle.
  - No done pulse; a partial vector remains in the banks.
  - Next start restarts from the newly captured base_addr.

Decomposition:
- Shared package:
  - NUM_BANKS, ADDR_W, DATA_W, CNT_W constants.
  - Loader state enum {IDLE, LOAD, DONE}.
  - Lane index type (3 bits).
  - Bank-slot mapping constants (A1=0, B1=1, A2=2, B2=3, A3=4, B3=5), shared with the MAC read sequencer.
- One sub-module: mac_loader_cursor. It holds the lane, cur_addr and remaining counters, plus a last_beat flag. The FSM and output registers stay in the top level.

Test Plan:
- Basic load:
  - Stimulus: rst, then start with base_addr=1, vec_count=1; stream 6 words 0x0011..0x0016 with in_valid held.
  - Response: bram_we one-hot 0x01,0x02,0x04,0x08,0x10,0x20 on consecutive cycles, all addr=1, data matching. done pulses with the 0x20 write, then busy=0.
- Multi-vector with gaps:
  - Stimulus: base_addr=10, vec_count=3, 18 words, in_valid deasserted every third cycle.
  - Response: exactly 18 writes; addresses 10×6, 11×6, 12×6; no we during gaps; single done.
- Wrap:
  - Stimulus: base_addr=255, vec_count=2.
  - Response: first vector at addr 255, second at addr 0; done after 12 writes.
- Zero count:
  - Stimulus: start with vec_count=0.
  - Response: in_ready never high; no we; done=1 the cycle after start; busy high for that one cycle only.
- Start ignored while busy:
  - Stimulus: second start with base_addr=50 mid-load of base_addr=5, vec_count=1.
  - Response: all writes at addr 5; one done.
- Reset mid-load:
  - Stimulus: assert rst after 3 accepted words.
  - Response: we=0, in_ready=0, busy=0 immediately; no done. A new start with base_addr=7 writes lane 0 at addr 7 first.
